// File: rtl/rr_arbiter_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rr_arbiter_ctrl_pkg
// Shared definitions for the round-robin arbiter controller.
//   state_t : controller FSM states
//     ST_IDLE    - no grant outstanding, waiting for any request
//     ST_GRANT   - one requester owns the resource
//     ST_RELEASE - one-cycle bus turnaround after a grant ends
// ---------------------------------------------------------------------------
package rr_arbiter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage : rr_arbiter_ctrl_pkg

// File: rtl/rr_arbiter_ctrl_pointer.sv
// ---------------------------------------------------------------------------
// rr_pointer
// One-hot round-robin priority register. The set bit marks the requester
// that has highest priority on the next arbitration.
//   clock  in  1  system clock, rising edge
//   reset  in  1  asynchronous active-low reset (pointer -> bit 0)
//   load   in  1  capture onehot rotated left by one position
//   onehot in  N  one-hot value to rotate (the grant being released)
//   ptr    out N  current one-hot priority pointer
// ---------------------------------------------------------------------------
module rr_pointer #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] onehot,
    output logic [N-1:0] ptr
);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= {{(N-1){1'b0}}, 1'b1};
        end else if (load) begin
            // Bit N-1 wraps around to bit 0.
            ptr <= {onehot[N-2:0], onehot[N-1]};
        end
    end

endmodule : rr_pointer

// File: rtl/rr_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// rr_arbiter_ctrl
// Round-robin arbiter sharing one resource among N requesters. A grant is
// held while the winner keeps requesting, and is force-released after
// MAX_HOLD cycles so no requester can starve the others. Every grant is
// followed by exactly one idle (RELEASE) cycle.
//   clock    in  1          system clock, rising edge
//   reset    in  1          asynchronous active-low reset
//   req      in  N          level requests, one per requester
//   grant    out N          registered one-hot grant, zero when idle
//   grant_id out clog2(N)   index of the granted requester, 0 when idle
//   busy     out 1          high whenever grant is non-zero
//   timeout  out 1          one-cycle pulse on a forced (MAX_HOLD) release
// ---------------------------------------------------------------------------
module rr_arbiter_ctrl
    import rr_arbiter_ctrl_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 timeout
);

    localparam int ID_W  = $clog2(N);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    state_t             state;
    logic [CNT_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]   hold_nxt;
    logic               hold_done;
    logic               win_req;
    logic               release_now;
    logic [N-1:0]       ptr;

    logic [2*N-1:0]     dbl_req;
    logic [2*N-1:0]     dbl_mask;
    logic [2*N-1:0]     masked;
    logic               any_req;
    logic [ID_W-1:0]    win_id;
    logic [N-1:0]       win_onehot;

    // -----------------------------------------------------------------------
    // Winner select: duplicate req so a scan that starts at the pointer and
    // runs off the top lands in the second copy, which is the wrap to bit 0.
    // Subtracting one from the pointer yields ones below it; inverting keeps
    // the pointer position and everything above.
    // -----------------------------------------------------------------------
    assign dbl_req  = {req, req};
    assign dbl_mask = ~({{N{1'b0}}, ptr} - {{(2*N-1){1'b0}}, 1'b1});
    assign masked   = dbl_req & dbl_mask;
    assign any_req  = |req;

    // NOTE: every variable assigned in always_comb gets a default at the top
    // so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        logic found;
        found  = 1'b0;
        win_id = '0;
        for (int i = 0; i < 2*N; i++) begin
            if (!found && masked[i]) begin
                found  = 1'b1;
                win_id = ID_W'(i % N);
            end
        end
    end

    assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win_id;

    // -----------------------------------------------------------------------
    // Hold tracking: hold_nxt is the number of grant cycles completed at this
    // edge. A dropped request takes precedence over the hold limit, so a
    // coincident drop is a normal release without a timeout pulse.
    // -----------------------------------------------------------------------
    assign hold_nxt    = hold_cnt + CNT_W'(1);
    assign hold_done   = (hold_nxt == CNT_W'(MAX_HOLD));
    assign win_req     = req[grant_id];
    assign release_now = (state == ST_GRANT) && (!win_req || hold_done);

    rr_pointer #(.N(N)) u_pointer (
        .clock  (clock),
        .reset  (reset),
        .load   (release_now),
        .onehot (grant),
        .ptr    (ptr)
    );

    // -----------------------------------------------------------------------
    // Controller FSM with registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_RELEASE: begin
                    timeout  <= 1'b0;
                    hold_cnt <= '0;
                    if (any_req) begin
                        state    <= ST_GRANT;
                        grant    <= win_onehot;
                        grant_id <= win_id;
                        busy     <= 1'b1;
                    end else begin
                        state    <= ST_IDLE;
                        grant    <= '0;
                        grant_id <= '0;
                        busy     <= 1'b0;
                    end
                end

                ST_GRANT: begin
                    hold_cnt <= hold_nxt;
                    if (release_now) begin
                        state    <= ST_RELEASE;
                        grant    <= '0;
                        grant_id <= '0;
                        busy     <= 1'b0;
                        timeout  <= win_req;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                    grant    <= '0;
                    grant_id <= '0;
                    busy     <= 1'b0;
                    timeout  <= 1'b0;
                end
            endcase
        end
    end

endmodule : rr_arbiter_ctrl

// File: tb/tb_rr_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_ctrl
// Directed bench for rr_arbiter_ctrl (N=4, MAX_HOLD=4). Each step drives req,
// advances a behavioural reference model, pushes the expected outputs onto a
// scoreboard queue, then pops and compares after the clock edge.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_ctrl;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    typedef struct packed {
        logic [N-1:0] grant;
        logic [1:0]   id;
        logic         busy;
        logic         timeout;
    } exp_t;

    logic         clock;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t sb_q[$];

    // Reference model state: 0 idle, 1 grant, 2 release
    int   m_state;
    int   m_ptr;
    int   m_win;
    int   m_held;
    exp_t m_out;

    rr_arbiter_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ptr   = 0;
        m_win   = 0;
        m_held  = 0;
        m_out   = '0;
    endtask

    // Advance the model by one clock edge with request vector r.
    task automatic model_step(input logic [N-1:0] r);
        bit found;
        case (m_state)
            1: begin
                if (!r[m_win]) begin
                    m_ptr   = (m_win + 1) % N;
                    m_state = 2;
                    m_out   = '0;
                end else if (m_held == MAX_HOLD) begin
                    m_ptr   = (m_win + 1) % N;
                    m_state = 2;
                    m_out   = '0;
                    m_out.timeout = 1'b1;
                end else begin
                    m_held++;
                end
            end
            default: begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (!found && r[idx]) begin
                        found = 1'b1;
                        m_win = idx;
                    end
                end
                if (found) begin
                    m_state = 1;
                    m_held  = 1;
                    m_out.grant   = 4'(1 << m_win);
                    m_out.id      = 2'(m_win);
                    m_out.busy    = 1'b1;
                    m_out.timeout = 1'b0;
                end else begin
                    m_state = 0;
                    m_out   = '0;
                end
            end
        endcase
    endtask

    task automatic compare(input exp_t e);
        check($sformatf("cyc%0d grant", cyc),    32'(grant),    32'(e.grant));
        check($sformatf("cyc%0d grant_id", cyc), 32'(grant_id), 32'(e.id));
        check($sformatf("cyc%0d busy", cyc),     32'(busy),     32'(e.busy));
        check($sformatf("cyc%0d timeout", cyc),  32'(timeout),  32'(e.timeout));
    endtask

    // One clock cycle with req = r; outputs sampled 1 time unit after the edge.
    task automatic step(input logic [N-1:0] r);
        exp_t e;
        req = r;
        model_step(r);
        sb_q.push_back(m_out);
        @(posedge clock);
        #1;
        cyc++;
        e = sb_q.pop_front();
        compare(e);
    endtask

    // Asynchronous reset: outputs must clear without waiting for an edge.
    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        #1;
        compare('0);
        @(posedge clock);
        @(posedge clock);
        #1;
        compare('0);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        #2;
        apply_reset();

        // Single requester: 2-cycle grant, release, idle (pointer -> 1)
        step(4'b0001); step(4'b0001); step(4'b0000); step(4'b0000); step(4'b0000);

        // Move pointer to 2, then req=0011 wraps to grant requester 0
        step(4'b0010); step(4'b0000); step(4'b0000);
        step(4'b0011); step(4'b0011); step(4'b0000); step(4'b0000);

        // All requesting: rotation with MAX_HOLD-cycle grants and timeouts
        for (int i = 0; i < 24; i++) step(4'b1111);
        step(4'b0000); step(4'b0000);

        // No preemption: requester 3 waits until requester 1 drops
        step(4'b0010); step(4'b1010); step(4'b1010); step(4'b1000);
        step(4'b1000); step(4'b0000); step(4'b0000);

        // Winner drops in its last allowed cycle: normal release, no timeout
        step(4'b0100); step(4'b0100); step(4'b0100); step(4'b0100);
        step(4'b0000); step(4'b0000);

        // Reset mid-grant (requester 3 granted with pointer at 3)
        step(4'b1111); step(4'b1111); step(4'b1111);
        apply_reset();
        step(4'b1001); step(4'b0000); step(4'b0000);
        step(4'b1000); step(4'b1000); step(4'b0000); step(4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rr_arbiter_ctrl
